// File: rtl/johnson_seq_pkg.sv
// Shared types and constants for the Johnson phase sequencer.
// State enum, the six legal codes, the two illegal codes, next-code helper.
package johnson_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  localparam logic [2:0] CODE_P0 = 3'b000;
  localparam logic [2:0] CODE_P1 = 3'b001;
  localparam logic [2:0] CODE_P2 = 3'b011;
  localparam logic [2:0] CODE_P3 = 3'b111;
  localparam logic [2:0] CODE_P4 = 3'b110;
  localparam logic [2:0] CODE_P5 = 3'b100;

  localparam logic [2:0] CODE_BAD_A = 3'b010;
  localparam logic [2:0] CODE_BAD_B = 3'b101;

  // Twisted ring: shift left, feed back the inverted MSB.
  function automatic logic [2:0] johnson_next(input logic [2:0] c);
    return {c[1:0], ~c[2]};
  endfunction

  function automatic logic is_illegal(input logic [2:0] c);
    return (c == CODE_BAD_A) || (c == CODE_BAD_B);
  endfunction

endpackage

// File: rtl/johnson3_counter.sv
// 3-bit six-state Johnson counter with clear and enable.
// Ports: clk, rstn, en, clr (wins over en), code, illegal (comb detect).
module johnson3_counter
  import johnson_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] code,
  output logic       illegal
);

  logic [2:0] code_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_q <= CODE_P0;
    end else if (clr) begin
      code_q <= CODE_P0;
    end else if (en) begin
      code_q <= johnson_next(code_q);
    end
  end

  assign code    = code_q;
  assign illegal = is_illegal(code_q);

endmodule

// File: rtl/johnson_phase_sequencer.sv
// Multi-round six-phase timing generator around a Johnson counter.
// Ports: clk, rstn, start, rounds, abort, step_mode, step -> busy, done, code, phase, round_cnt, err_illegal.
module johnson_phase_sequencer
  import johnson_seq_pkg::*;
#(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [RW-1:0] rounds,
  input  logic          abort,
  input  logic          step_mode,
  input  logic          step,
  output logic          busy,
  output logic          done,
  output logic [2:0]    code,
  output logic [5:0]    phase,
  output logic [RW-1:0] round_cnt,
  output logic          err_illegal
);

  seq_state_t    state;
  logic [RW-1:0] rounds_lat;
  logic [RW-1:0] rc_inc;
  logic          illegal;
  logic          adv;
  logic          cnt_en;
  logic          cnt_clr;
  logic          wrap;

  assign adv    = ~step_mode | step;
  assign rc_inc = round_cnt + {{(RW-1){1'b0}}, 1'b1};
  assign wrap   = (code == CODE_P5);

  // Counter sits at 000 in IDLE; abort and upset recovery also clear it.
  assign cnt_clr = (state == IDLE) | abort | illegal;
  assign cnt_en  = (state == RUN) & adv;

  johnson3_counter u_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .code    (code),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      done        <= 1'b0;
      round_cnt   <= '0;
      rounds_lat  <= '0;
      err_illegal <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err_illegal <= 1'b0;
            if (rounds != '0) begin
              state      <= RUN;
              round_cnt  <= '0;
              rounds_lat <= rounds;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (illegal) begin
            err_illegal <= 1'b1;
          end else if (adv && wrap) begin
            round_cnt <= rc_inc;
            if (rc_inc == rounds_lat) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    phase = 6'b000000;
    if (busy) begin
      case (code)
        CODE_P0: phase = 6'b000001;
        CODE_P1: phase = 6'b000010;
        CODE_P2: phase = 6'b000100;
        CODE_P3: phase = 6'b001000;
        CODE_P4: phase = 6'b010000;
        CODE_P5: phase = 6'b100000;
        default: phase = 6'b000000;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_sequencer.sv
// Directed self-checking bench for johnson_phase_sequencer.
// Drives and samples 1ns after each rising edge.
module tb_johnson_phase_sequencer;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [RW-1:0] rounds = '0;
  logic          abort = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          busy;
  logic          done;
  logic [2:0]    code;
  logic [5:0]    phase;
  logic [RW-1:0] round_cnt;
  logic          err_illegal;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] seq [0:6] = '{3'b000, 3'b001, 3'b011, 3'b111,
                            3'b110, 3'b100, 3'b000};

  johnson_phase_sequencer #(.RW(RW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .rounds      (rounds),
    .abort       (abort),
    .step_mode   (step_mode),
    .step        (step),
    .busy        (busy),
    .done        (done),
    .code        (code),
    .phase       (phase),
    .round_cnt   (round_cnt),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [RW-1:0] r);
    rounds = r;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic run_out(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
  endtask

  int n;
  int dn;
  int nst;

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_code", code, 0);
    chk("rst_phase", phase, 0);
    chk("rst_rc", round_cnt, 0);
    chk("rst_err", err_illegal, 0);
    rstn = 1'b1;
    tick();

    // one free-running round
    go(4'd1);
    for (int k = 0; k < 6; k++) begin
      chk("r1_code", code, seq[k]);
      chk("r1_phase", phase, 32'd1 << k);
      chk("r1_busy", busy, 1);
      chk("r1_done", done, 0);
      tick();
    end
    chk("r1_busy_end", busy, 0);
    chk("r1_done", done, 1);
    chk("r1_rc", round_cnt, 1);
    chk("r1_code_end", code, 0);
    chk("r1_phase_end", phase, 0);
    tick();
    chk("r1_done_drop", done, 0);
    chk("r1_rc_hold", round_cnt, 1);

    // three rounds, start retried mid-run
    go(4'd3);
    n = 0;
    dn = 0;
    while (busy && n < 200) begin
      n++;
      if (done) dn++;
      if (n == 7) chk("r3_rc1", round_cnt, 1);
      if (n == 13) chk("r3_rc2", round_cnt, 2);
      start  = (n == 5);
      rounds = (n == 5) ? 4'd1 : 4'd3;
      tick();
    end
    start = 1'b0;
    chk("r3_cycles", n, 18);
    chk("r3_early_done", dn, 0);
    chk("r3_done", done, 1);
    chk("r3_rc", round_cnt, 3);
    tick();
    chk("r3_done_drop", done, 0);

    // single step every third cycle
    step_mode = 1'b1;
    go(4'd1);
    nst = 0;
    for (int i = 1; i <= 18; i++) begin
      step = (i % 3 == 0);
      tick();
      if (step) nst++;
      if (i < 18) begin
        chk("st_code", code, seq[nst]);
        chk("st_busy", busy, 1);
      end
    end
    step = 1'b0;
    step_mode = 1'b0;
    chk("st_done", done, 1);
    chk("st_busy_end", busy, 0);
    tick();

    // abort in round two at code 111
    go(4'd2);
    for (int k = 0; k < 9; k++) tick();
    chk("ab_code_pre", code, 3'b111);
    chk("ab_rc_pre", round_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_code", code, 0);
    chk("ab_done", done, 0);
    chk("ab_rc", round_cnt, 1);
    tick();
    chk("ab_done2", done, 0);
    abort = 1'b1;
    go(4'd1);
    abort = 1'b0;
    chk("ab_restart_busy", busy, 1);
    chk("ab_restart_rc", round_cnt, 0);
    run_out(n);
    chk("ab_restart_cyc", n, 6);
    chk("ab_restart_done", done, 1);
    tick();

    // upset to 101 in round two of three
    go(4'd3);
    for (int k = 0; k < 9; k++) tick();
    chk("up_code_pre", code, 3'b111);
    force dut.u_cnt.code_q = 3'b101;
    #1;
    release dut.u_cnt.code_q;
    #1;
    chk("up_code_bad", code, 3'b101);
    chk("up_phase_bad", phase, 0);
    tick();
    chk("up_code", code, 0);
    chk("up_err", err_illegal, 1);
    chk("up_rc", round_cnt, 1);
    chk("up_busy", busy, 1);
    run_out(n);
    chk("up_cycles", n, 12);
    chk("up_done", done, 1);
    chk("up_rc_end", round_cnt, 3);
    chk("up_err_sticky", err_illegal, 1);
    tick();
    go(4'd1);
    chk("up_err_clr", err_illegal, 0);
    run_out(n);
    tick();

    // async reset mid-run at 110, then a zero-round start
    go(4'd3);
    for (int k = 0; k < 10; k++) tick();
    chk("rs_code_pre", code, 3'b110);
    rstn = 1'b0;
    #1;
    chk("rs_code", code, 0);
    chk("rs_busy", busy, 0);
    chk("rs_phase", phase, 0);
    chk("rs_rc", round_cnt, 0);
    #1;
    rstn = 1'b1;
    tick();
    go(4'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    tick();
    chk("z_done_drop", done, 0);
    chk("z_busy2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
